// File: rtl/sobel_frame_scheduler.sv
// -----------------------------------------------------------------------------
// sobel_frame_scheduler
//   Moves one image frame from the SPI pixel receiver through the Sobel core.
//   It forwards received pixels to the core, tracks the input column and row,
//   injects zero pixels after the last input pixel so the core pipeline
//   empties, and buffers the core results in a small show-ahead FIFO that the
//   SPI transmit side pops.
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   start_i                 begins a frame (honoured only when idle)
//   rx_px_i / rx_valid_i    pixel from the SPI receiver
//   sobel_px_o / _valid_o   pixel to the Sobel core (one cycle after rx)
//   sobel_px_i / _valid_i   result from the Sobel core
//   tx_px_o / tx_empty_o    FIFO head word (zero when empty) and empty flag
//   tx_pop_i                removes the FIFO head
//   col_o / row_o           position of the next input pixel
//   line_end_o              marks the last pixel of a row on the core side
//   busy_o / frame_done_o   frame in progress / one-cycle completion pulse
//   overflow_o              sticky FIFO overflow or unexpected rx pixel
// -----------------------------------------------------------------------------
module sobel_frame_scheduler #(
    parameter int PX_BITS      = 24,
    parameter int IMG_WIDTH    = 16,
    parameter int IMG_HEIGHT   = 16,
    parameter int FLUSH_PIXELS = 18,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [PX_BITS-1:0]            rx_px_i,
    input  logic                          rx_valid_i,
    output logic [PX_BITS-1:0]            sobel_px_o,
    output logic                          sobel_valid_o,
    input  logic [PX_BITS-1:0]            sobel_px_i,
    input  logic                          sobel_valid_i,
    output logic [PX_BITS-1:0]            tx_px_o,
    output logic                          tx_empty_o,
    input  logic                          tx_pop_i,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
    output logic                          line_end_o,
    output logic                          busy_o,
    output logic                          frame_done_o,
    output logic                          overflow_o
);

    localparam int FRAME_PX = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W    = $clog2(FRAME_PX + 1);
    localparam int COL_W    = $clog2(IMG_WIDTH);
    localparam int ROW_W    = $clog2(IMG_HEIGHT);
    localparam int FL_W     = $clog2(FLUSH_PIXELS + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] FRAME_PX_C  = CNT_W'(FRAME_PX);
    localparam logic [CNT_W-1:0] LAST_PX_C   = CNT_W'(FRAME_PX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
    localparam logic [COL_W-1:0] COL_LAST_C  = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_ONE_C   = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST_C  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_ONE_C   = ROW_W'(1);
    localparam logic [FL_W-1:0]  FL_LAST_C   = FL_W'(FLUSH_PIXELS - 1);
    localparam logic [FL_W-1:0]  FL_ONE_C    = FL_W'(1);
    localparam logic [AW-1:0]    PTR_ONE_C   = AW'(1);
    localparam logic [AW:0]      FIFO_FULL_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      FIFO_ONE_C  = (AW+1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [PX_BITS-1:0]  sobel_px_r;
    logic                sobel_valid_r, line_end_r, overflow_r;
    logic [COL_W-1:0]    col_r;
    logic [ROW_W-1:0]    row_r;
    logic [CNT_W-1:0]    in_cnt_r, out_cnt_r;
    logic [FL_W-1:0]     flush_cnt_r;
    logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
    logic [AW:0]         fifo_cnt_r;
    logic [PX_BITS-1:0]  fifo_mem_r [FIFO_DEPTH];

    logic start_s, accept_s, flush_s, capture_s, rx_err_s;
    logic in_frame_s, full_s, empty_s, push_s, pop_s, drop_s;

    assign empty_s    = (fifo_cnt_r == '0);
    assign full_s     = (fifo_cnt_r == FIFO_FULL_C);
    assign pop_s      = tx_pop_i && !empty_s;
    // Results past the frame count are not counted as pushes or drops.
    assign in_frame_s = capture_s && (out_cnt_r < FRAME_PX_C);
    // A pop in the same cycle frees the slot, so push-at-full is legal then.
    assign push_s     = in_frame_s && (!full_s || pop_s);
    assign drop_s     = in_frame_s && full_s && !pop_s;

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        accept_s    = 1'b0;
        flush_s     = 1'b0;
        capture_s   = 1'b0;
        rx_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                capture_s = sobel_valid_i;
                accept_s  = rx_valid_i;
                if (rx_valid_i && (in_cnt_r == LAST_PX_C)) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                capture_s = sobel_valid_i;
                flush_s   = 1'b1;
                rx_err_s  = rx_valid_i;
                if (flush_cnt_r == FL_LAST_C) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                capture_s = sobel_valid_i;
                rx_err_s  = rx_valid_i;
                if ((out_cnt_r == FRAME_PX_C) && empty_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                rx_err_s    = rx_valid_i;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= ST_IDLE;
        else         state_r <= state_nxt_s;
    end

    // Core-side pixel stream: forwarded rx pixels, then zero flush pixels.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sobel_px_r    <= '0;
            sobel_valid_r <= 1'b0;
            line_end_r    <= 1'b0;
        end else if (accept_s) begin
            sobel_px_r    <= rx_px_i;
            sobel_valid_r <= 1'b1;
            line_end_r    <= (col_r == COL_LAST_C);
        end else if (flush_s) begin
            sobel_px_r    <= '0;
            sobel_valid_r <= 1'b1;
            line_end_r    <= 1'b0;
        end else begin
            sobel_px_r    <= '0;
            sobel_valid_r <= 1'b0;
            line_end_r    <= 1'b0;
        end
    end

    // Input position, input count and flush count.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            col_r       <= '0;
            row_r       <= '0;
            in_cnt_r    <= '0;
            flush_cnt_r <= '0;
        end else if (start_s) begin
            col_r       <= '0;
            row_r       <= '0;
            in_cnt_r    <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (accept_s) begin
                in_cnt_r <= in_cnt_r + CNT_ONE_C;
                if (col_r == COL_LAST_C) begin
                    col_r <= '0;
                    row_r <= (row_r == ROW_LAST_C) ? '0 : row_r + ROW_ONE_C;
                end else begin
                    col_r <= col_r + COL_ONE_C;
                end
            end
            if (flush_s) flush_cnt_r <= flush_cnt_r + FL_ONE_C;
        end
    end

    // Result count and sticky error flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_cnt_r  <= '0;
            overflow_r <= 1'b0;
        end else if (start_s) begin
            out_cnt_r  <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (in_frame_s)          out_cnt_r  <= out_cnt_r + CNT_ONE_C;
            if (drop_s || rx_err_s)  overflow_r <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; a start flushes any leftover words.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else if (start_s) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + FIFO_ONE_C;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - FIFO_ONE_C;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // FIFO storage; contents are masked by the empty flag so need no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= sobel_px_i;
    end

    assign sobel_px_o    = sobel_px_r;
    assign sobel_valid_o = sobel_valid_r;
    assign line_end_o    = line_end_r;
    assign col_o         = col_r;
    assign row_o         = row_r;
    assign overflow_o    = overflow_r;
    assign tx_empty_o    = empty_s;
    assign tx_px_o       = empty_s ? '0 : fifo_mem_r[rd_ptr_r];
    assign busy_o        = (state_r != ST_IDLE);
    assign frame_done_o  = (state_r == ST_DONE);

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
module tb_sobel_frame_scheduler;

    localparam int PXB = 24;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int FL  = 6;
    localparam int D   = 4;

    logic           clk_i = 1'b0;
    logic           reset_i = 1'b1;
    logic           start_i = 1'b0;
    logic [PXB-1:0] rx_px_i = '0;
    logic           rx_valid_i = 1'b0;
    logic [PXB-1:0] sobel_px_o;
    logic           sobel_valid_o;
    logic [PXB-1:0] sobel_px_i = '0;
    logic           sobel_valid_i = 1'b0;
    logic [PXB-1:0] tx_px_o;
    logic           tx_empty_o;
    logic           tx_pop_i = 1'b0;
    logic [1:0]     col_o;
    logic [1:0]     row_o;
    logic           line_end_o, busy_o, frame_done_o, overflow_o;

    int total = 0;
    int bad   = 0;

    sobel_frame_scheduler #(
        .PX_BITS(PXB), .IMG_WIDTH(W), .IMG_HEIGHT(H),
        .FLUSH_PIXELS(FL), .FIFO_DEPTH(D)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .rx_px_i(rx_px_i), .rx_valid_i(rx_valid_i),
        .sobel_px_o(sobel_px_o), .sobel_valid_o(sobel_valid_o),
        .sobel_px_i(sobel_px_i), .sobel_valid_i(sobel_valid_i),
        .tx_px_o(tx_px_o), .tx_empty_o(tx_empty_o), .tx_pop_i(tx_pop_i),
        .col_o(col_o), .row_o(row_o), .line_end_o(line_end_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Flag vector: {sobel_valid, line_end, busy, frame_done, overflow, tx_empty, row, col}
    task automatic test_reset();
        reset_i = 1'b1;
        #12;
        total++;
        if ({sobel_valid_o, line_end_o, busy_o, frame_done_o, overflow_o, tx_empty_o, row_o, col_o} !== 10'b0000010000) begin
            $display("FAIL reset_flags: got %b expected %b", {sobel_valid_o, line_end_o, busy_o, frame_done_o, overflow_o, tx_empty_o, row_o, col_o}, 10'b0000010000);
            bad++;
        end
        total++;
        if ({sobel_px_o, tx_px_o} !== 48'h0) begin
            $display("FAIL reset_data: got %h expected 0", {sobel_px_o, tx_px_o});
            bad++;
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic start_frame();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic test_full_frame();
        start_frame();
        total++;
        if ({busy_o, row_o, col_o} !== 5'b10000) begin
            $display("FAIL ff_start: got %b expected 10000", {busy_o, row_o, col_o});
            bad++;
        end
        for (int p = 1; p <= 16; p++) begin
            rx_valid_i = 1'b1;
            rx_px_i    = PXB'(p);
            @(negedge clk_i);
            rx_valid_i = 1'b0;
            total++;
            if ({sobel_valid_o, sobel_px_o} !== {1'b1, PXB'(p)}) begin
                $display("FAIL ff_px%0d: got v=%b px=%h expected v=1 px=%h", p, sobel_valid_o, sobel_px_o, p);
                bad++;
            end
            total++;
            if (line_end_o !== ((p % 4) == 0)) begin
                $display("FAIL ff_line_end%0d: got %b expected %b", p, line_end_o, (p % 4) == 0);
                bad++;
            end
            total++;
            if ({row_o, col_o} !== {2'((p / 4) % 4), 2'(p % 4)}) begin
                $display("FAIL ff_pos%0d: got row=%0d col=%0d expected row=%0d col=%0d", p, row_o, col_o, (p / 4) % 4, p % 4);
                bad++;
            end
            if (p < 16) begin
                for (int g = 0; g < 2; g++) begin
                    @(negedge clk_i);
                    total++;
                    if (sobel_valid_o !== 1'b0) begin
                        $display("FAIL ff_gap%0d: got valid=%b expected 0", p, sobel_valid_o);
                        bad++;
                    end
                end
            end
        end
        for (int f = 0; f < FL; f++) begin
            @(negedge clk_i);
            total++;
            if ({sobel_valid_o, sobel_px_o} !== {1'b1, PXB'(0)}) begin
                $display("FAIL ff_flush%0d: got v=%b px=%h expected v=1 px=0", f, sobel_valid_o, sobel_px_o);
                bad++;
            end
        end
        @(negedge clk_i);
        total++;
        if ({sobel_valid_o, busy_o} !== 2'b01) begin
            $display("FAIL ff_after_flush: got valid/busy=%b expected 01", {sobel_valid_o, busy_o});
            bad++;
        end
    endtask

    task automatic test_drain_done();
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        int done_cnt = 0;
        int done_idx = -1;
        int busy_idx = -1;
        while (popped < 16 && cyc < 100) begin
            @(negedge clk_i);
            if (!tx_empty_o) begin
                total++;
                if (tx_px_o !== PXB'(32'hA0 + popped)) begin
                    $display("FAIL dd_tx%0d: got %h expected %h", popped, tx_px_o, 32'hA0 + popped);
                    bad++;
                end
                tx_pop_i = 1'b1;
                popped++;
            end else begin
                tx_pop_i = 1'b0;
            end
            if (pushed < 16) begin
                sobel_valid_i = 1'b1;
                sobel_px_i    = PXB'(32'hA0 + pushed);
                pushed++;
            end else begin
                sobel_valid_i = 1'b0;
            end
            cyc++;
        end
        total++;
        if (popped != 16) begin
            $display("FAIL dd_pop_count: got %0d expected 16", popped);
            bad++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            tx_pop_i      = 1'b0;
            sobel_valid_i = 1'b0;
            if (frame_done_o) begin
                done_cnt++;
                done_idx = i;
            end
            if (!busy_o && busy_idx < 0) busy_idx = i;
        end
        total++;
        if (done_cnt != 1) begin
            $display("FAIL dd_done_count: got %0d expected 1", done_cnt);
            bad++;
        end
        total++;
        if (busy_idx != done_idx + 1 || done_idx < 0) begin
            $display("FAIL dd_busy_fall: got busy low at %0d expected %0d", busy_idx, done_idx + 1);
            bad++;
        end
        total++;
        if ({tx_empty_o, overflow_o} !== 2'b10) begin
            $display("FAIL dd_end_flags: got empty/ovf=%b expected 10", {tx_empty_o, overflow_o});
            bad++;
        end
    endtask

    task automatic test_protocol_error();
        int strobes = 0;
        int nonzero = 0;
        start_frame();
        for (int p = 1; p <= 16; p++) begin
            rx_valid_i = 1'b1;
            rx_px_i    = PXB'(32'h100 + p);
            start_i    = (p == 6);
            @(negedge clk_i);
            total++;
            if ({sobel_valid_o, sobel_px_o, row_o, col_o} !== {1'b1, PXB'(32'h100 + p), 2'((p / 4) % 4), 2'(p % 4)}) begin
                $display("FAIL pe_px%0d: got v=%b px=%h row=%0d col=%0d expected v=1 px=%h row=%0d col=%0d",
                         p, sobel_valid_o, sobel_px_o, row_o, col_o, 32'h100 + p, (p / 4) % 4, p % 4);
                bad++;
            end
        end
        start_i    = 1'b0;
        rx_px_i    = PXB'(32'h5A5A);
        total++;
        if (overflow_o !== 1'b0) begin
            $display("FAIL pe_ovf_before: got %b expected 0", overflow_o);
            bad++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            rx_valid_i = 1'b0;
            if (sobel_valid_o) begin
                strobes++;
                if (sobel_px_o != '0) nonzero++;
            end
        end
        total++;
        if (strobes != FL || nonzero != 0) begin
            $display("FAIL pe_strobes: got %0d strobes %0d nonzero expected %0d strobes 0 nonzero", strobes, nonzero, FL);
            bad++;
        end
        total++;
        if (overflow_o !== 1'b1) begin
            $display("FAIL pe_ovf: got %b expected 1", overflow_o);
            bad++;
        end
    endtask

    task automatic test_fifo_overflow();
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        start_frame();
        for (int k = 0; k < 5; k++) begin
            sobel_valid_i = 1'b1;
            sobel_px_i    = PXB'(32'hA0 + k);
            @(negedge clk_i);
            if (k == 3) begin
                total++;
                if ({overflow_o, tx_empty_o} !== 2'b00) begin
                    $display("FAIL fo_full_no_ovf: got ovf/empty=%b expected 00", {overflow_o, tx_empty_o});
                    bad++;
                end
            end
        end
        sobel_valid_i = 1'b0;
        total++;
        if ({overflow_o, tx_empty_o, tx_px_o} !== {2'b10, PXB'(32'hA0)}) begin
            $display("FAIL fo_ovf: got ovf=%b empty=%b head=%h expected ovf=1 empty=0 head=a0", overflow_o, tx_empty_o, tx_px_o);
            bad++;
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({tx_empty_o, tx_px_o} !== {1'b0, PXB'(32'hA0 + k)}) begin
                $display("FAIL fo_pop%0d: got empty=%b head=%h expected empty=0 head=%h", k, tx_empty_o, tx_px_o, 32'hA0 + k);
                bad++;
            end
            tx_pop_i = 1'b1;
            @(negedge clk_i);
        end
        tx_pop_i = 1'b0;
        total++;
        if ({tx_empty_o, tx_px_o} !== {1'b1, PXB'(0)}) begin
            $display("FAIL fo_empty: got empty=%b head=%h expected empty=1 head=0", tx_empty_o, tx_px_o);
            bad++;
        end
    endtask

    task automatic test_boundary();
        for (int k = 0; k < 4; k++) begin
            sobel_valid_i = 1'b1;
            sobel_px_i    = PXB'(32'hB0 + k);
            @(negedge clk_i);
        end
        sobel_valid_i = 1'b1;
        sobel_px_i    = PXB'(32'hB4);
        tx_pop_i      = 1'b1;
        @(negedge clk_i);
        sobel_valid_i = 1'b0;
        tx_pop_i      = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            total++;
            if ({tx_empty_o, tx_px_o} !== {1'b0, PXB'(32'hB0 + k)}) begin
                $display("FAIL bd_pushpop%0d: got empty=%b head=%h expected empty=0 head=%h", k, tx_empty_o, tx_px_o, 32'hB0 + k);
                bad++;
            end
            tx_pop_i = 1'b1;
            @(negedge clk_i);
        end
        total++;
        if (tx_empty_o !== 1'b1) begin
            $display("FAIL bd_occupancy: got empty=%b expected 1", tx_empty_o);
            bad++;
        end
        @(negedge clk_i);
        tx_pop_i = 1'b0;
        @(negedge clk_i);
        total++;
        if ({tx_empty_o, tx_px_o} !== {1'b1, PXB'(0)}) begin
            $display("FAIL bd_empty_pop: got empty=%b head=%h expected empty=1 head=0", tx_empty_o, tx_px_o);
            bad++;
        end
        sobel_valid_i = 1'b1;
        sobel_px_i    = PXB'(32'hC0);
        @(negedge clk_i);
        sobel_valid_i = 1'b0;
        total++;
        if ({tx_empty_o, tx_px_o} !== {1'b0, PXB'(32'hC0)}) begin
            $display("FAIL bd_after_empty_pop: got empty=%b head=%h expected empty=0 head=c0", tx_empty_o, tx_px_o);
            bad++;
        end
    endtask

    task automatic test_mid_reset();
        int done_cnt = 0;
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        start_frame();
        sobel_valid_i = 1'b1;
        sobel_px_i    = PXB'(32'hD0);
        for (int p = 1; p <= 7; p++) begin
            rx_valid_i = 1'b1;
            rx_px_i    = PXB'(32'h200 + p);
            @(negedge clk_i);
            sobel_valid_i = 1'b0;
        end
        rx_valid_i = 1'b0;
        total++;
        if ({sobel_valid_o, busy_o, tx_empty_o, row_o, col_o} !== 7'b1100111) begin
            $display("FAIL mr_pre: got %b expected 1100111", {sobel_valid_o, busy_o, tx_empty_o, row_o, col_o});
            bad++;
        end
        #2;
        reset_i = 1'b1;
        #1;
        total++;
        if ({sobel_valid_o, line_end_o, busy_o, frame_done_o, overflow_o, tx_empty_o, row_o, col_o} !== 10'b0000010000) begin
            $display("FAIL mr_flags: got %b expected 0000010000", {sobel_valid_o, line_end_o, busy_o, frame_done_o, overflow_o, tx_empty_o, row_o, col_o});
            bad++;
        end
        total++;
        if ({sobel_px_o, tx_px_o} !== 48'h0) begin
            $display("FAIL mr_data: got %h expected 0", {sobel_px_o, tx_px_o});
            bad++;
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (frame_done_o || busy_o) done_cnt++;
        end
        total++;
        if (done_cnt != 0) begin
            $display("FAIL mr_no_done: got %0d busy/done cycles expected 0", done_cnt);
            bad++;
        end
        start_frame();
        total++;
        if ({busy_o, row_o, col_o} !== 5'b10000) begin
            $display("FAIL mr_restart: got %b expected 10000", {busy_o, row_o, col_o});
            bad++;
        end
        rx_valid_i = 1'b1;
        rx_px_i    = PXB'(32'h77);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        total++;
        if ({sobel_valid_o, sobel_px_o, row_o, col_o} !== {1'b1, PXB'(32'h77), 2'd0, 2'd1}) begin
            $display("FAIL mr_first_px: got v=%b px=%h row=%0d col=%0d expected v=1 px=77 row=0 col=1", sobel_valid_o, sobel_px_o, row_o, col_o);
            bad++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_drain_done();
        test_protocol_error();
        test_fifo_overflow();
        test_boundary();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
